// File: rtl/f9pcap_tx_arbiter.sv
// Frame-level round-robin AXI-Stream arbiter: merges NUM_PORTS sources into one
// registered output, aborting frames whose source stalls too long mid-frame.
module f9pcap_tx_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int STALL_TIMEOUT   = 64
) (
    input  logic                                   tx_axis_clk,
    input  logic                                   tx_axis_rst,

    input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                   s_axis_tready,
    input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
    input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,

    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tuser,
    output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]             m_axis_tkeep,

    output logic [15:0]                            stat_abort_count,
    output logic [$clog2(NUM_PORTS)-1:0]           grant_port,
    output logic                                   busy
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int SW = 16;
    localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_ABORT,
        ST_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [GW-1:0]               grant_q, grant_d;
    logic [GW-1:0]               last_grant_q, last_grant_d;
    logic [SW-1:0]               stall_q, stall_d;
    logic [15:0]                 abort_cnt_q, abort_cnt_d;

    logic                        m_valid_q, m_valid_d;
    logic                        m_last_q, m_last_d;
    logic                        m_user_q, m_user_d;
    logic [AXIS_DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [AXIS_KEEP_WIDTH-1:0]  m_keep_q, m_keep_d;

    logic [AXIS_DATA_WIDTH-1:0]  port_data [NUM_PORTS];
    logic [AXIS_KEEP_WIDTH-1:0]  port_keep [NUM_PORTS];

    logic                        can_load;
    logic                        g_valid;
    logic                        g_last;
    logic [GW-1:0]               rr_pick;
    logic                        rr_found;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign port_data[gi] = s_axis_tdata[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        assign port_keep[gi] = s_axis_tkeep[gi*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    end

    assign can_load = !m_valid_q || m_axis_tready;
    assign g_valid  = s_axis_tvalid[grant_q];
    assign g_last   = s_axis_tlast[grant_q];

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int idx;
        rr_pick  = last_grant_q;
        rr_found = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_PORTS;
            if (!rr_found && s_axis_tvalid[GW'(idx)]) begin
                rr_pick  = GW'(idx);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        stall_d       = stall_q;
        abort_cnt_d   = abort_cnt_q;
        m_valid_d     = m_valid_q;
        m_last_d      = m_last_q;
        m_user_d      = m_user_q;
        m_data_d      = m_data_q;
        m_keep_d      = m_keep_q;
        s_axis_tready = '0;

        // The sink empties the stage; a load below refills it in the same cycle.
        if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    stall_d = '0;
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                s_axis_tready[grant_q] = can_load;
                if (g_valid && can_load) begin
                    m_valid_d = 1'b1;
                    m_data_d  = port_data[grant_q];
                    m_keep_d  = port_keep[grant_q];
                    m_last_d  = g_last;
                    m_user_d  = 1'b0;
                    stall_d   = '0;
                    if (g_last) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end else if (!g_valid) begin
                    // Only a silent source counts; output backpressure never does.
                    stall_d = stall_q + SW'(1);
                    if (stall_d == STALL_LIMIT) begin
                        state_d = ST_ABORT;
                    end
                end
            end

            ST_ABORT: begin
                if (can_load) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_keep_d  = AXIS_KEEP_WIDTH'(1);
                    m_last_d  = 1'b1;
                    m_user_d  = 1'b1;
                    stall_d   = '0;
                    if (abort_cnt_q != 16'hFFFF) begin
                        abort_cnt_d = abort_cnt_q + 16'd1;
                    end
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                s_axis_tready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_axis_clk) begin
        if (tx_axis_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_PORTS - 1);
            stall_q      <= '0;
            abort_cnt_q  <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_user_q     <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            abort_cnt_q  <= abort_cnt_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
        end
    end

    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tlast     = m_last_q;
    assign m_axis_tuser     = m_user_q;
    assign m_axis_tdata     = m_data_q;
    assign m_axis_tkeep     = m_keep_q;
    assign stat_abort_count = abort_cnt_q;
    assign grant_port       = grant_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_f9pcap_tx_arbiter.sv
// Bench for f9pcap_tx_arbiter: queued AXIS sources, a rule-level reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
`timescale 1ns/1ps
module tb_f9pcap_tx_arbiter;
    localparam int NP = 3;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int TO = 64;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   s_tvalid = '0;
    logic [NP-1:0]   s_tready;
    logic [NP-1:0]   s_tlast = '0;
    logic [NP*DW-1:0] s_tdata = '0;
    logic [NP*KW-1:0] s_tkeep = '0;
    logic            m_tvalid, m_tlast, m_tuser;
    logic            m_tready = 1'b0;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [15:0]     stat;
    logic [GW-1:0]   gport;
    logic            busy;

    always #5 clk = ~clk;

    f9pcap_tx_arbiter #(
        .NUM_PORTS(NP), .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .STALL_TIMEOUT(TO)
    ) dut (
        .tx_axis_clk(clk), .tx_axis_rst(rst),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .stat_abort_count(stat), .grant_port(gport), .busy(busy)
    );

    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; int gap; } beat_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic user; } obs_t;

    beat_t src_q [NP][$];
    obs_t  olog[$];

    int checks = 0, passes = 0, fails = 0, cyc = 0;
    logic rst_i = 1'b1, mrdy_i = 1'b1;

    // Reference model: arbitration owner, stall count, abort tally and the one-deep output stage.
    localparam int M_IDLE = 0, M_XFER = 1, M_ABORT = 2, M_DRAIN = 3;
    int mode = M_IDLE, owner = 0, last_g = NP - 1, idle_cnt = 0, abort_ct = 0;
    logic st_valid = 0, st_last = 0, st_user = 0;
    logic [DW-1:0] st_data = '0;
    logic [KW-1:0] st_keep = '0;
    logic model_ok = 1'b0;

    function automatic logic [DW-1:0] mkdata(int port, int tag, int beat);
        return {8'hA0 + 8'(port), 24'(tag), 32'(beat)};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            fails++;
            if (fails <= 40) $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_frame(int p, int tag, int len, int gap_idx, int gap_len);
        for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = mkdata(p, tag, b);
            bt.keep = 8'hFF;
            bt.last = (b == len - 1);
            bt.gap  = (b == gap_idx) ? gap_len : 0;
            src_q[p].push_back(bt);
        end
    endtask

    task automatic push_random_frame(int p);
        int len = $urandom_range(1, 6);
        int long_idx = ($urandom_range(0, 14) == 0) ? $urandom_range(1, 5) : -1;
        for (int b = 0; b < len; b++) begin
            beat_t bt;
            bt.data = {$urandom, $urandom};
            bt.keep = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            bt.last = (b == len - 1);
            bt.gap  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            if (b == long_idx) bt.gap = $urandom_range(60, 70);
            src_q[p].push_back(bt);
        end
    endtask

    task automatic flush_sources();
        for (int p = 0; p < NP; p++) src_q[p].delete();
    endtask

    function automatic logic [NP-1:0] model_tready();
        logic [NP-1:0] r;
        r = '0;
        if (mode == M_XFER) r[owner] = !st_valid || mrdy_i;
        else if (mode == M_DRAIN) r[owner] = 1'b1;
        return r;
    endfunction

    task automatic model_step(logic [NP-1:0] tv, logic [NP-1:0] tl);
        logic can_load, push, pl, pu, found;
        logic [DW-1:0] pd;
        logic [KW-1:0] pk;
        can_load = !st_valid || mrdy_i;
        push = 0; pl = 0; pu = 0; pd = '0; pk = '0; found = 0;
        if (rst_i) begin
            mode = M_IDLE; owner = 0; last_g = NP - 1; idle_cnt = 0; abort_ct = 0;
            st_valid = 0; st_last = 0; st_user = 0; st_data = '0; st_keep = '0;
            model_ok = 1'b1;
            return;
        end
        case (mode)
            M_IDLE: if (tv != '0) begin
                for (int k = 1; k <= NP; k++) begin
                    if (!found && tv[(last_g + k) % NP]) begin
                        owner = (last_g + k) % NP;
                        found = 1;
                    end
                end
                mode = M_XFER;
                idle_cnt = 0;
            end
            M_XFER: begin
                if (tv[owner] && can_load) begin
                    push = 1; pd = s_tdata[owner*DW +: DW]; pk = s_tkeep[owner*KW +: KW];
                    pl = tl[owner]; pu = 0; idle_cnt = 0;
                    if (tl[owner]) begin last_g = owner; mode = M_IDLE; end
                end else if (!tv[owner]) begin
                    idle_cnt++;
                    if (idle_cnt >= TO) mode = M_ABORT;
                end
            end
            M_ABORT: if (can_load) begin
                push = 1; pd = '0; pk = 8'h01; pl = 1; pu = 1;
                if (abort_ct < 65535) abort_ct++;
                mode = M_DRAIN;
            end
            default: if (tv[owner] && tl[owner]) begin
                last_g = owner; mode = M_IDLE;
            end
        endcase
        if (push) begin
            st_valid = 1; st_data = pd; st_keep = pk; st_last = pl; st_user = pu;
        end else if (mrdy_i) begin
            st_valid = 0;
        end
    endtask

    // One clock: drive at negedge, compare DUT against the model, then advance both.
    task automatic cycle();
        logic [NP-1:0] tv, tl, rdy;
        obs_t o;
        for (int p = 0; p < NP; p++) begin
            tv[p] = 0; tl[p] = 0;
            if (src_q[p].size() > 0) begin
                if (src_q[p][0].gap > 0) src_q[p][0].gap = src_q[p][0].gap - 1;
                else begin
                    tv[p] = 1; tl[p] = src_q[p][0].last;
                    s_tdata[p*DW +: DW] = src_q[p][0].data;
                    s_tkeep[p*KW +: KW] = src_q[p][0].keep;
                end
            end
            if (!tv[p]) begin
                s_tdata[p*DW +: DW] = {$urandom, $urandom};
                s_tkeep[p*KW +: KW] = 8'($urandom);
                tl[p] = 1'($urandom);
            end
        end
        s_tvalid = tv; s_tlast = tl; m_tready = mrdy_i; rst = rst_i;
        #1;
        rdy = model_tready();
        if (model_ok) begin
            chk("m_tvalid", m_tvalid, st_valid);
            if (st_valid) begin
                chk("m_tdata", m_tdata, st_data);
                chk("m_tkeep", m_tkeep, st_keep);
                chk("m_tlast", m_tlast, st_last);
                chk("m_tuser", m_tuser, st_user);
            end
            chk("busy", busy, mode != M_IDLE);
            if (mode != M_IDLE) chk("grant_port", gport, owner);
            chk("stat_abort_count", stat, abort_ct);
            chk("s_tready", s_tready, rdy);
            if (m_tvalid && m_tready) begin
                o.cyc = cyc; o.data = m_tdata; o.keep = m_tkeep; o.last = m_tlast; o.user = m_tuser;
                olog.push_back(o);
            end
        end
        for (int p = 0; p < NP; p++) if (tv[p] && rdy[p]) void'(src_q[p].pop_front());
        model_step(tv, tl);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until_idle(string name, int budget);
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size()) != 0 ||
               mode != M_IDLE || st_valid) begin
            cycle();
            n++;
            if (n >= budget) begin
                checks++; fails++;
                $display("FAIL %s budget cycle=%0d got=busy want=idle within %0d", name, cyc, budget);
                break;
            end
        end
    endtask

    initial begin
        int t0;
        @(negedge clk);
        rst_i = 1; mrdy_i = 1;
        repeat (3) cycle();
        rst_i = 0;

        chk("rst m_tvalid", m_tvalid, 0);
        chk("rst m_tdata", m_tdata, 0);
        chk("rst m_tkeep", m_tkeep, 0);
        chk("rst m_tlast", m_tlast, 0);
        chk("rst busy", busy, 0);
        chk("rst grant", gport, 0);
        chk("rst stat", stat, 0);

        // Two simultaneous 4-beat frames: port 0 first, one arbitration cycle between frames.
        olog.delete();
        push_frame(0, 1, 4, -1, 0);
        push_frame(1, 2, 4, -1, 0);
        t0 = cyc;
        run_until_idle("r031", 200);
        chk("r031 beats", olog.size(), 8);
        if (olog.size() == 8) begin
            chk("r031 first cycle", olog[0].cyc, t0 + 2);
            chk("r031 p1 start", olog[4].cyc, t0 + 7);
            for (int i = 0; i < 8; i++) begin
                chk("r031 data", olog[i].data, (i < 4) ? mkdata(0, 1, i) : mkdata(1, 2, i - 4));
                chk("r031 user", olog[i].user, 0);
                if (i % 4 != 0) chk("r031 contiguous", olog[i].cyc, olog[i-1].cyc + 1);
            end
        end

        // Port 0 keeps requesting; port 1 must alternate with it.
        olog.delete();
        for (int f = 0; f < 3; f++) begin
            push_frame(0, 10 + f, 2, -1, 0);
            push_frame(1, 20 + f, 2, -1, 0);
        end
        run_until_idle("r032", 300);
        begin
            int fi = 0;
            foreach (olog[i]) if (olog[i].last) begin
                chk("r032 frame port", olog[i].data[63:56], 8'hA0 + 8'(fi % 2));
                fi++;
            end
            chk("r032 frames", fi, 6);
        end

        // 64 idle cycles mid-frame: two beats, then the abort marker, rest drained.
        olog.delete();
        push_frame(1, 30, 5, 2, 64);
        run_until_idle("r033", 400);
        chk("r033 beats", olog.size(), 3);
        if (olog.size() == 3) begin
            chk("r033 b0", olog[0].data, mkdata(1, 30, 0));
            chk("r033 b1", olog[1].data, mkdata(1, 30, 1));
            chk("r033 abort data", olog[2].data, 0);
            chk("r033 abort keep", olog[2].keep, 8'h01);
            chk("r033 abort last", olog[2].last, 1);
            chk("r033 abort user", olog[2].user, 1);
        end
        chk("r033 stat", stat, 1);

        // 63 idle cycles is still within budget: whole frame, no abort.
        olog.delete();
        push_frame(1, 40, 5, 2, 63);
        run_until_idle("r034", 400);
        chk("r034 beats", olog.size(), 5);
        if (olog.size() == 5)
            for (int i = 0; i < 5; i++) begin
                chk("r034 data", olog[i].data, mkdata(1, 40, i));
                chk("r034 user", olog[i].user, 0);
            end
        chk("r034 stat", stat, 1);

        // Long output backpressure: beat held, inputs blocked, no abort, nothing lost.
        olog.delete();
        mrdy_i = 0;
        push_frame(0, 50, 4, -1, 0);
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (i == 100) begin
                chk("r035 held valid", m_tvalid, 1);
                chk("r035 held data", m_tdata, mkdata(0, 50, 0));
                chk("r035 in tready", s_tready, 0);
            end
        end
        mrdy_i = 1;
        run_until_idle("r035", 100);
        chk("r035 beats", olog.size(), 4);
        if (olog.size() == 4)
            for (int i = 0; i < 4; i++) chk("r035 data", olog[i].data, mkdata(0, 50, i));
        chk("r035 stat", stat, 1);

        // Reset while beat 3 of a 6-beat frame is accepted.
        push_frame(1, 60, 6, -1, 0);
        repeat (3) cycle();
        rst_i = 1;
        cycle();
        rst_i = 0;
        flush_sources();
        chk("r036 m_tvalid", m_tvalid, 0);
        chk("r036 busy", busy, 0);
        olog.delete();
        push_frame(1, 70, 2, -1, 0);
        push_frame(0, 71, 2, -1, 0);
        run_until_idle("r036", 100);
        chk("r036 beats", olog.size(), 4);
        if (olog.size() > 0) chk("r036 first port", olog[0].data, mkdata(0, 71, 0));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            mrdy_i = ($urandom_range(0, 9) < 7);
            for (int p = 0; p < NP; p++)
                if (src_q[p].size() < 8 && $urandom_range(0, 5) == 0) push_random_frame(p);
            rst_i = ($urandom_range(0, 999) == 0);
            cycle();
            if (rst_i) begin
                flush_sources();
                rst_i = 0;
            end
        end
        mrdy_i = 1;
        run_until_idle("random drain", 4000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
